// File: rtl/bmu_wb_stage.sv
// Writeback stage behind the bit-manipulation unit: tracks issued ops through the
// fixed BMU latency, buffers results in a credit-protected FIFO, and drains them in order.
module bmu_wb_stage #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int BMU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       flush_in,
    input  logic                       issue_valid_in,
    input  logic [TAG_W-1:0]           issue_rd_in,
    output logic                       issue_ready_out,
    input  logic [31:0]                bmu_result_in,
    input  logic                       bmu_error_in,
    output logic                       wb_valid_out,
    input  logic                       wb_ready_in,
    output logic [TAG_W-1:0]           wb_rd_out,
    output logic [31:0]                wb_data_out,
    output logic                       wb_error_out,
    output logic [$clog2(DEPTH):0]     occupancy_out,
    output logic                       overflow_err_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [BMU_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]   pipe_rd_q [BMU_LAT];
    logic [TAG_W-1:0]   pipe_rd_d [BMU_LAT];

    logic [TAG_W-1:0]   mem_rd_q   [DEPTH];
    logic [TAG_W-1:0]   mem_rd_d   [DEPTH];
    logic [31:0]        mem_data_q [DEPTH];
    logic [31:0]        mem_data_d [DEPTH];
    logic [DEPTH-1:0]   mem_err_q, mem_err_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [CNT_W-1:0]   inflight_s;
    logic [CNT_W:0]     credit_used_s;
    logic               issue_ready_s, issue_ok_s;
    logic               cap_s, push_req_s, full_s, push_s, pop_s, wb_valid_s;
    logic [TAG_W-1:0]   cap_rd_s;

    // Credit accounting and handshake decode, all from registered state.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < BMU_LAT; i++) begin
            inflight_s = inflight_s + CNT_W'(pipe_vld_q[i]);
        end
        credit_used_s = {1'b0, count_q} + {1'b0, inflight_s};
        issue_ready_s = (credit_used_s < (CNT_W+1)'(DEPTH));
        issue_ok_s    = issue_valid_in & issue_ready_s;
        cap_s         = pipe_vld_q[BMU_LAT-1];
        cap_rd_s      = pipe_rd_q[BMU_LAT-1];
        // x0 writes are dropped unless they carry an error worth reporting.
        push_req_s    = cap_s & ((cap_rd_s != {TAG_W{1'b0}}) | bmu_error_in);
        full_s        = (count_q == CNT_W'(DEPTH));
        push_s        = push_req_s & ~full_s;
        wb_valid_s    = (count_q != {CNT_W{1'b0}});
        pop_s         = wb_valid_s & wb_ready_in;
    end

    // Next-state for tag pipeline, FIFO storage, pointers and sticky error.
    always_comb begin
        pipe_vld_d = pipe_vld_q;
        pipe_rd_d  = pipe_rd_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        mem_err_d  = mem_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (issue_valid_in & ~issue_ready_s) | (push_req_s & full_s);

        pipe_vld_d[0] = issue_ok_s;
        pipe_rd_d[0]  = issue_rd_in;
        for (int i = 1; i < BMU_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_rd_d[i]  = pipe_rd_q[i-1];
        end

        if (push_s) begin
            mem_rd_d[wr_ptr_q]   = cap_rd_s;
            mem_data_d[wr_ptr_q] = bmu_result_in;
            mem_err_d[wr_ptr_q]  = bmu_error_in;
        end else begin
            mem_err_d = mem_err_q;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
        count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

        // Flush overrides issue, capture and pop; the sticky error survives it.
        if (flush_in) begin
            pipe_vld_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            count_d = count_d;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < BMU_LAT; i++) begin
                pipe_rd_q[i] <= '0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_rd_q[j]   <= '0;
                mem_data_q[j] <= 32'h0000_0000;
            end
            mem_err_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_rd_q  <= pipe_rd_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            mem_err_q  <= mem_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign issue_ready_out  = issue_ready_s;
    assign wb_valid_out     = wb_valid_s;
    assign wb_rd_out        = mem_rd_q[rd_ptr_q];
    assign wb_data_out      = mem_data_q[rd_ptr_q];
    assign wb_error_out     = mem_err_q[rd_ptr_q];
    assign occupancy_out    = count_q;
    assign overflow_err_out = overflow_q;

endmodule

// File: tb/tb_bmu_wb_stage.sv
// Directed bench for bmu_wb_stage: stimulus queues expected writebacks, a monitor
// pops and compares on every accepted handshake.
module tb_bmu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        flush_in = 1'b0;
    logic        issue_valid_in = 1'b0;
    logic [4:0]  issue_rd_in = 5'd0;
    logic        issue_ready_out;
    logic [31:0] bmu_result_in = 32'h0000_0000;
    logic        bmu_error_in = 1'b0;
    logic        wb_valid_out;
    logic        wb_ready_in = 1'b0;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;
    logic        wb_error_out;
    logic [2:0]  occupancy_out;
    logic        overflow_err_out;

    int          compared = 0;
    int          mismatched = 0;
    logic [37:0] exp_q [$];
    logic [37:0] exp_e;
    int          n_acc;
    int          next_rd;

    bmu_wb_stage #(.DEPTH(4), .TAG_W(5), .BMU_LAT(1)) dut (
        .clk(clk), .rst_l(rst_l), .flush_in(flush_in),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
        .issue_ready_out(issue_ready_out),
        .bmu_result_in(bmu_result_in), .bmu_error_in(bmu_error_in),
        .wb_valid_out(wb_valid_out), .wb_ready_in(wb_ready_in),
        .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out), .wb_error_out(wb_error_out),
        .occupancy_out(occupancy_out), .overflow_err_out(overflow_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: present an issue, then after the edge drive the BMU result for it.
    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic e);
        logic acc;
        issue_valid_in = v;
        issue_rd_in    = rd;
        acc = v && issue_ready_out;
        if (acc && !flush_in && (rd != 5'd0 || e)) exp_q.push_back({rd, d, e});
        @(posedge clk);
        #1;
        issue_valid_in = 1'b0;
        flush_in       = 1'b0;
        bmu_result_in  = acc ? d : 32'hFFFF_FFFF;
        bmu_error_in   = acc ? e : 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0000_0000, 1'b0);
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, 64'({wb_valid_out, wb_rd_out, wb_data_out, wb_error_out,
                       occupancy_out, overflow_err_out, issue_ready_out}),
                  64'({1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1}));
    endtask

    // Scoreboard monitor: compare every accepted writeback against the queue head.
    always @(negedge clk) begin
        if (rst_l && wb_valid_out && wb_ready_in) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL wb_unexpected: got rd=%0d data=%08h err=%0b expected no output",
                         wb_rd_out, wb_data_out, wb_error_out);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wb_head", 64'({wb_rd_out, wb_data_out, wb_error_out}), 64'(exp_e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset_state");
        rst_l = 1'b1;
        @(posedge clk);
        #1;

        // Single op with one-cycle BMU latency.
        wb_ready_in = 1'b0;
        step(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
        chk("single_not_yet", 64'(wb_valid_out), 64'(1'b0));
        idle();
        chk("single_valid", 64'(wb_valid_out), 64'(1'b1));
        chk("single_occ1", 64'(occupancy_out), 64'(3'd1));
        wb_ready_in = 1'b1;
        idle();
        chk("single_occ0", 64'(occupancy_out), 64'(3'd0));

        // Backpressure: only DEPTH credits may be consumed.
        wb_ready_in = 1'b0;
        n_acc = 0;
        next_rd = 1;
        for (int i = 0; i < 8; i++) begin
            if (issue_ready_out && next_rd <= 6) begin
                step(1'b1, 5'(next_rd), 32'hA000_0000 + 32'(next_rd), 1'b0);
                next_rd++;
                n_acc++;
            end else begin
                idle();
            end
        end
        chk("bp_accepted", 64'(n_acc), 64'(4));
        chk("bp_occ_full", 64'(occupancy_out), 64'(3'd4));
        chk("bp_ready_low", 64'(issue_ready_out), 64'(1'b0));
        wb_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("bp_ready_after_pop", 64'(issue_ready_out), 64'(1'b1));
            chk("bp_drain_occ", 64'(occupancy_out), 64'(3 - k));
        end

        // x0 filtering.
        wb_ready_in = 1'b0;
        step(1'b1, 5'd0, 32'h1111_1111, 1'b0);
        idle();
        chk("x0_discard_occ", 64'(occupancy_out), 64'(3'd0));
        chk("x0_credit_back", 64'(issue_ready_out), 64'(1'b1));
        step(1'b1, 5'd0, 32'hCAFE_0001, 1'b1);
        idle();
        chk("x0_err_pushed", 64'(occupancy_out), 64'(3'd1));
        chk("x0_err_flag", 64'(wb_error_out), 64'(1'b1));
        wb_ready_in = 1'b1;
        idle();
        chk("x0_err_drained", 64'(occupancy_out), 64'(3'd0));

        // Steady push+pop at count 2 across several pointer wraps.
        wb_ready_in = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) wb_ready_in = 1'b1;
            if (k >= 3) chk("pp_occ_steady", 64'(occupancy_out), 64'(3'd2));
            step(1'b1, 5'(10 + k), 32'hB000_0000 + 32'(k), 1'b0);
        end
        repeat (4) idle();
        chk("pp_drained", 64'(occupancy_out), 64'(3'd0));

        // Illegal issue while full, then flush keeps the sticky error.
        wb_ready_in = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 7; i++) begin
            if (issue_ready_out && n_acc < 4) begin
                step(1'b1, 5'(25 + n_acc), 32'hC000_0000 + 32'(n_acc), 1'b0);
                n_acc++;
            end else begin
                idle();
            end
        end
        chk("ovf_full_occ", 64'(occupancy_out), 64'(3'd4));
        chk("ovf_clear_before", 64'(overflow_err_out), 64'(1'b0));
        step(1'b1, 5'd29, 32'hDEAD_0029, 1'b0);
        chk("ovf_set", 64'(overflow_err_out), 64'(1'b1));
        chk("ovf_occ_unchanged", 64'(occupancy_out), 64'(3'd4));
        wb_ready_in = 1'b1;
        repeat (4) idle();
        chk("ovf_drained", 64'(occupancy_out), 64'(3'd0));
        wb_ready_in = 1'b0;
        flush_in = 1'b1;
        idle();
        chk("ovf_survives_flush", 64'(overflow_err_out), 64'(1'b1));

        // Flush with two buffered, one in flight and a concurrent issue.
        step(1'b1, 5'd5, 32'hD000_0005, 1'b0);
        step(1'b1, 5'd6, 32'hD000_0006, 1'b0);
        step(1'b1, 5'd7, 32'hD000_0007, 1'b0);
        chk("fl_pre_occ", 64'(occupancy_out), 64'(3'd2));
        exp_q.delete();
        flush_in = 1'b1;
        step(1'b1, 5'd8, 32'hD000_0008, 1'b0);
        chk("fl_state", 64'({occupancy_out, wb_valid_out, issue_ready_out}),
                        64'({3'd0, 1'b0, 1'b1}));
        wb_ready_in = 1'b1;
        repeat (4) idle();
        chk("fl_no_late_capture", 64'(occupancy_out), 64'(3'd0));

        // Asynchronous reset in the middle of traffic.
        wb_ready_in = 1'b0;
        step(1'b1, 5'd9, 32'hE000_0009, 1'b0);
        step(1'b1, 5'd10, 32'hE000_000A, 1'b0);
        #2;
        rst_l = 1'b0;
        #1;
        check_reset_vals("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        wb_ready_in = 1'b1;
        step(1'b1, 5'd12, 32'h1234_5678, 1'b0);
        repeat (3) idle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
